mouse_init_seq: RTL and testbench

MOUSE_INIT_SEQ -- requirements
Module: mouse_init_seq

---
 rtl/mouse_init_seq_if.sv | 24 ++
 rtl/mouse_init_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_mouse_init_seq.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mouse_init_seq_if.sv
// Byte-level handshake between the mouse init sequencer and the PS/2 transmit/receive engines.
interface mouse_init_seq_if;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       tx_done_tick;
    logic       wr_ps2;
    logic [7:0] tx_data;

    modport master (
        input  rx_data,
        input  rx_done_tick,
        input  tx_done_tick,
        output wr_ps2,
        output tx_data
    );

    modport slave (
        output rx_data,
        output rx_done_tick,
        output tx_done_tick,
        input  wr_ps2,
        input  tx_data
    );
endinterface

// File: rtl/mouse_init_seq.sv
// PS/2 mouse power-up sequencer: reset, set sample rate, enable streaming, with resend,
// timeout and bounded full-sequence retry handling.
//
// state   | meaning
// IDLE    | one-cycle landing state after reset or start
// SEND    | issue the current step's command byte
// WAIT_TX | wait for the transmitter to finish the byte
// WAIT_RX | wait for the next response byte
// CHECK   | compare the captured byte against the expected response
// DONE    | sequence complete, streaming enabled
// FAIL    | retries exhausted
// RETRY   | restart from step 0 or give up
module mouse_init_seq #(
    parameter logic [7:0]  SAMPLE_RATE = 8'd100,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    mouse_init_seq_if.master bus,
    output logic             stream_en,
    output logic             init_err,
    output logic [1:0]       retry_cnt,
    output logic [3:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_TX = 3'd2,
        WAIT_RX = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        FAIL    = 3'd6,
        RETRY   = 3'd7
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd3;
    localparam logic [1:0] MAX_FE    = 2'd2;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [1:0]  rx_idx_q, rx_idx_d;
    logic [1:0]  fe_cnt_q, fe_cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic [23:0] timer_q, timer_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        wr_q, wr_d;
    logic [7:0]  tx_q, tx_d;
    logic        stream_q, stream_d;
    logic        err_q, err_d;
    logic        timeout;

    function automatic logic [7:0] cmd_byte(input logic [2:0] step);
        case (step)
            3'd0:    cmd_byte = 8'hFF;
            3'd1:    cmd_byte = 8'hF3;
            3'd2:    cmd_byte = SAMPLE_RATE;
            3'd3:    cmd_byte = 8'hF4;
            default: cmd_byte = 8'h00;
        endcase
    endfunction

    // Step 0 (reset) answers ACK, BAT-passed, device ID; every other step answers ACK only.
    function automatic logic [7:0] exp_byte(input logic [2:0] step, input logic [1:0] idx);
        if (step == 3'd0) begin
            case (idx)
                2'd0:    exp_byte = 8'hFA;
                2'd1:    exp_byte = 8'hAA;
                default: exp_byte = 8'h00;
            endcase
        end else begin
            exp_byte = 8'hFA;
        end
    endfunction

    function automatic logic [1:0] last_idx(input logic [2:0] step);
        last_idx = (step == 3'd0) ? 2'd2 : 2'd0;
    endfunction

    assign timeout = (timer_q == TIMEOUT_CYC - 24'd1);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        rx_idx_d  = rx_idx_q;
        fe_cnt_d  = fe_cnt_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        rx_byte_d = rx_byte_q;

        if (start) begin
            state_d  = IDLE;
            step_d   = 3'd0;
            rx_idx_d = 2'd0;
            fe_cnt_d = 2'd0;
            retry_d  = 2'd0;
            timer_d  = 24'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SEND;
                    step_d   = 3'd0;
                    rx_idx_d = 2'd0;
                    fe_cnt_d = 2'd0;
                end
                SEND: begin
                    state_d = WAIT_TX;
                    timer_d = 24'd0;
                end
                WAIT_TX: begin
                    if (bus.tx_done_tick) begin
                        state_d  = WAIT_RX;
                        timer_d  = 24'd0;
                        rx_idx_d = 2'd0;
                    end else if (timeout) begin
                        state_d = RETRY;
                    end else begin
                        timer_d = timer_q + 24'd1;
                    end
                end
                WAIT_RX: begin
                    // A byte arriving in the timeout cycle still wins.
                    if (bus.rx_done_tick) begin
                        rx_byte_d = bus.rx_data;
                        timer_d   = 24'd0;
                        state_d   = CHECK;
                    end else if (timeout) begin
                        state_d = RETRY;
                    end else begin
                        timer_d = timer_q + 24'd1;
                    end
                end
                CHECK: begin
                    if (rx_byte_q == exp_byte(step_q, rx_idx_q)) begin
                        fe_cnt_d = 2'd0;
                        if (rx_idx_q == last_idx(step_q)) begin
                            rx_idx_d = 2'd0;
                            if (step_q == LAST_STEP) begin
                                state_d = DONE;
                            end else begin
                                step_d  = step_q + 3'd1;
                                state_d = SEND;
                            end
                        end else begin
                            rx_idx_d = rx_idx_q + 2'd1;
                            state_d  = WAIT_RX;
                        end
                    end else if (rx_byte_q == 8'hFE && fe_cnt_q < MAX_FE) begin
                        fe_cnt_d = fe_cnt_q + 2'd1;
                        rx_idx_d = 2'd0;
                        state_d  = SEND;
                    end else begin
                        state_d = RETRY;
                    end
                end
                RETRY: begin
                    if ({30'd0, retry_q} < MAX_RETRY) begin
                        retry_d  = retry_q + 2'd1;
                        step_d   = 3'd0;
                        rx_idx_d = 2'd0;
                        fe_cnt_d = 2'd0;
                        state_d  = SEND;
                    end else begin
                        state_d = FAIL;
                    end
                end
                DONE, FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // The write strobe lands in the first WAIT_TX cycle, with tx_data already settled.
        wr_d     = (state_q == SEND) && (state_d == WAIT_TX);
        tx_d     = (state_d == SEND || state_d == WAIT_TX) ? cmd_byte(step_d) : 8'h00;
        stream_d = (state_d == DONE);
        err_d    = (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            step_q    <= 3'd0;
            rx_idx_q  <= 2'd0;
            fe_cnt_q  <= 2'd0;
            retry_q   <= 2'd0;
            timer_q   <= 24'd0;
            rx_byte_q <= 8'h00;
            wr_q      <= 1'b0;
            tx_q      <= 8'h00;
            stream_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            rx_idx_q  <= rx_idx_d;
            fe_cnt_q  <= fe_cnt_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            rx_byte_q <= rx_byte_d;
            wr_q      <= wr_d;
            tx_q      <= tx_d;
            stream_q  <= stream_d;
            err_q     <= err_d;
        end
    end

    assign bus.wr_ps2  = wr_q;
    assign bus.tx_data = tx_q;
    assign stream_en   = stream_q;
    assign init_err    = err_q;
    assign retry_cnt   = retry_q;
    assign state_dbg   = {1'b0, state_q};

endmodule

// File: tb/tb_mouse_init_seq.sv
// Bench for mouse_init_seq: a scripted PS/2 mouse/transmitter stand-in driven from a
// protocol-level reference that plans each reply and predicts commands and outcome.
module tb_mouse_init_seq;
    localparam int          TB_TO = 16;
    localparam logic [7:0]  TB_SR = 8'd100;
    localparam int unsigned TB_MR = 3;

    localparam int K_GOOD = 0, K_FE = 1, K_BAD = 2, K_FC = 3, K_SILENT = 4, K_PARTIAL = 5, K_AB = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stream_en;
    logic       init_err;
    logic [1:0] retry_cnt;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    mouse_init_seq_if bus();

    mouse_init_seq #(
        .SAMPLE_RATE(TB_SR),
        .TIMEOUT_CYC(24'(TB_TO)),
        .MAX_RETRY  (TB_MR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .stream_en(stream_en),
        .init_err (init_err),
        .retry_cnt(retry_cnt),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Protocol tables: command per step and the response bytes each step expects.
    logic [7:0] cmds [4]    = '{8'hFF, 8'hF3, TB_SR, 8'hF4};
    logic [7:0] rsp  [4][3] = '{'{8'hFA, 8'hAA, 8'h00}, '{8'hFA, 8'h00, 8'h00},
                                '{8'hFA, 8'h00, 8'h00}, '{8'hFA, 8'h00, 8'h00}};
    int         nrsp [4]    = '{3, 1, 1, 1};

    int         pol [64];
    int         pol_n;
    logic [7:0] scr_b [64][4];
    int         scr_n [64];
    logic [7:0] exp_cmd [64];
    int         exp_rty [64];
    int         n_tx, exp_done, exp_fail, exp_retry;

    function automatic void add_b(input int t, input logic [7:0] b);
        scr_b[t][scr_n[t]] = b;
        scr_n[t]++;
    endfunction

    // Walk the protocol at transaction level: plan each reply and predict the result.
    function automatic void build();
        int step = 0;
        int retries = 0;
        int fe = 0;
        bit fin = 0;
        logic [7:0] bad;
        n_tx = 0; exp_done = 0; exp_fail = 0;
        while (!fin && n_tx < 64) begin
            int k;
            bit adv;
            bit lost;
            k = (n_tx < pol_n) ? pol[n_tx] : K_GOOD;
            exp_cmd[n_tx] = cmds[step];
            exp_rty[n_tx] = retries;
            scr_n[n_tx] = 0; adv = 0; lost = 0;
            case (k)
                K_FE: begin
                    add_b(n_tx, 8'hFE);
                    if (fe < 2) fe++; else lost = 1;
                end
                K_BAD: begin
                    do bad = 8'($urandom_range(0, 255)); while (bad == 8'hFA || bad == 8'hFE);
                    add_b(n_tx, bad);
                    lost = 1;
                end
                K_FC: begin add_b(n_tx, 8'hFC); lost = 1; end
                K_SILENT: lost = 1;
                K_PARTIAL: begin
                    add_b(n_tx, rsp[step][0]);
                    if (nrsp[step] > 1) lost = 1; else adv = 1;
                end
                K_AB: begin
                    if (nrsp[step] > 1) add_b(n_tx, rsp[step][0]);
                    add_b(n_tx, 8'hAB);
                    lost = 1;
                end
                default: begin
                    for (int i = 0; i < nrsp[step]; i++) add_b(n_tx, rsp[step][i]);
                    adv = 1;
                end
            endcase
            n_tx++;
            if (adv) begin
                fe = 0;
                step++;
                if (step == 4) begin exp_done = 1; fin = 1; end
            end else if (lost) begin
                if (retries < int'(TB_MR)) begin
                    retries++; step = 0; fe = 0;
                end else begin
                    exp_fail = 1; fin = 1;
                end
            end
        end
        exp_retry = retries;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ":wr_ps2"}, 32'(bus.wr_ps2), 32'd0);
        check_eq({tag, ":tx_data"}, 32'(bus.tx_data), 32'd0);
        check_eq({tag, ":stream_en"}, 32'(stream_en), 32'd0);
        check_eq({tag, ":init_err"}, 32'(init_err), 32'd0);
        check_eq({tag, ":retry_cnt"}, 32'(retry_cnt), 32'd0);
    endtask

    task automatic wait_wr(output bit seen, output int cyc);
        cyc = 0;
        while (bus.wr_ps2 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        seen = (bus.wr_ps2 === 1'b1);
    endtask

    task automatic do_tx(input int t, input bit send_bytes, input bit prev_silent);
        bit seen;
        int cyc;
        wait_wr(seen, cyc);
        check_eq($sformatf("wr_seen[%0d]", t), 32'(seen), 32'd1);
        if (!seen) return;
        if (prev_silent) check_eq($sformatf("timeout_latency[%0d]", t), 32'(cyc), 32'(TB_TO + 2));
        check_eq($sformatf("tx_cmd[%0d]", t), 32'(bus.tx_data), 32'(exp_cmd[t]));
        check_eq($sformatf("retry_at_tx[%0d]", t), 32'(retry_cnt), 32'(exp_rty[t]));
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            check_eq($sformatf("wr_single[%0d]", t), 32'(bus.wr_ps2), 32'd0);
            check_eq($sformatf("tx_hold[%0d]", t), 32'(bus.tx_data), 32'(exp_cmd[t]));
        end
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        if (send_bytes) begin
            for (int i = 0; i < scr_n[t]; i++) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                bus.rx_data = scr_b[t][i];
                bus.rx_done_tick = 1'b1;
                @(negedge clk);
                bus.rx_done_tick = 1'b0;
                bus.rx_data = 8'($urandom);
            end
        end
    endtask

    task automatic run_scenario(input string tag);
        int cyc;
        int wr_extra;
        int both;
        for (int t = 0; t < n_tx; t++) do_tx(t, 1'b1, (t > 0) && (scr_n[t-1] == 0));
        cyc = 0;
        while (stream_en !== 1'b1 && init_err !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, ":stream_en"}, 32'(stream_en), 32'(exp_done));
        check_eq({tag, ":init_err"}, 32'(init_err), 32'(exp_fail));
        check_eq({tag, ":retry_cnt"}, 32'(retry_cnt), 32'(exp_retry));
        // Terminal states must ignore stray ticks and stay silent.
        wr_extra = 0; both = 0;
        repeat (40) begin
            bus.tx_done_tick = 1'($urandom);
            bus.rx_done_tick = 1'($urandom);
            bus.rx_data = 8'($urandom);
            @(negedge clk);
            if (bus.wr_ps2 === 1'b1) wr_extra++;
            if (stream_en === 1'b1 && init_err === 1'b1) both++;
        end
        bus.tx_done_tick = 1'b0;
        bus.rx_done_tick = 1'b0;
        check_eq({tag, ":no_wr_after_end"}, 32'(wr_extra), 32'd0);
        check_eq({tag, ":exclusive_flags"}, 32'(both), 32'd0);
        check_eq({tag, ":stream_en_held"}, 32'(stream_en), 32'(exp_done));
        check_eq({tag, ":init_err_held"}, 32'(init_err), 32'(exp_fail));
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_idle_outputs({tag, ":after_start"});
    endtask

    task automatic release_and_check(input string tag);
        int cyc;
        rst = 1'b1;
        cyc = 0;
        while (bus.wr_ps2 !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, ":first_wr_latency"}, 32'(cyc), 32'd2);
        check_eq({tag, ":first_wr_data"}, 32'(bus.tx_data), 32'hFF);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_done_tick = 1'b0;
        bus.tx_done_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        release_and_check("por");

        pol_n = 0;
        build();
        run_scenario("nominal");

        pulse_start("fe_once");
        pol[0] = K_GOOD; pol[1] = K_FE; pol_n = 2;
        build();
        run_scenario("fe_once");

        pulse_start("bad_bat");
        pol[0] = K_AB; pol_n = 1;
        build();
        run_scenario("bad_bat");

        pulse_start("silent");
        for (int i = 0; i < 4; i++) pol[i] = K_SILENT;
        pol_n = 4;
        build();
        run_scenario("silent");

        pulse_start("restart_from_fail");
        pol_n = 0;
        build();
        run_scenario("restart_from_fail");

        pulse_start("fe_triple");
        pol[0] = K_GOOD; pol[1] = K_FE; pol[2] = K_FE; pol[3] = K_FE; pol_n = 4;
        build();
        run_scenario("fe_triple");

        pulse_start("fc_on_f4");
        pol[0] = K_GOOD; pol[1] = K_GOOD; pol[2] = K_GOOD; pol[3] = K_FC; pol_n = 4;
        build();
        run_scenario("fc_on_f4");

        // start and a valid byte in the same cycle: start must win.
        pulse_start("start_prio");
        pol[0] = K_BAD; pol_n = 1;
        build();
        do_tx(0, 1'b1, 1'b0);
        do_tx(1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        bus.rx_data = 8'hFA;
        bus.rx_done_tick = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.rx_done_tick = 1'b0;
        check_idle_outputs("start_prio:after_start");
        pol_n = 0;
        build();
        run_scenario("start_prio");

        // Reset while waiting for the ACK to F3, after one retry has been consumed.
        pulse_start("rst_mid");
        pol[0] = K_BAD; pol_n = 1;
        build();
        do_tx(0, 1'b1, 1'b0);
        do_tx(1, 1'b1, 1'b0);
        do_tx(2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid:in_reset");
        repeat (2) @(negedge clk);
        release_and_check("rst_mid");
        pol_n = 0;
        build();
        run_scenario("rst_mid");

        for (int r = 0; r < 6; r++) begin
            pulse_start($sformatf("random%0d", r));
            pol_n = 10;
            for (int i = 0; i < pol_n; i++) begin
                int w;
                w = $urandom_range(0, 9);
                pol[i] = (w < 5) ? K_GOOD : (w == 5) ? K_FE : (w == 6) ? K_BAD :
                         (w == 7) ? K_FC : (w == 8) ? K_SILENT : K_PARTIAL;
            end
            build();
            run_scenario($sformatf("random%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
